// File: rtl/seven_seg_scan_ctrl.sv
// Three-digit seven-segment scan controller: sequential double-dabble binary-to-BCD
// conversion plus a time-multiplexed digit scan through one shared external decoder.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading-zero hundreds/tens digits.
module seven_seg_scan_ctrl #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] value,
  input  logic             load,
  output logic             busy,
  output logic             conv_done,
  output logic [3:0]       digit_bcd,
  input  logic [6:0]       seg_in,
  output logic [6:0]       seg_n,
  output logic [3:0]       an_n
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BCD_W = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [BCD_W-1:0]   scratch_q, scratch_d;
  logic [BCD_W-1:0]   disp_q, disp_d;
  logic [CNT_W-1:0]   iter_q, iter_d;
  logic               busy_d, done_d;
  logic [BCD_W-1:0]   adj;

  logic [REF_W-1:0]   ref_q;
  logic [1:0]         idx_q;
  logic               blank;

  // Double-dabble correction: add 3 to every nibble that is 5 or more.
  always_comb begin
    adj = scratch_q;
    for (int i = 0; i < 3; i++) begin
      if (scratch_q[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
      end
    end
  end

  // Conversion FSM next-state and datapath.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    scratch_d = scratch_q;
    iter_d    = iter_q;
    disp_d    = disp_q;
    busy_d    = busy;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          shreg_d   = value;
          scratch_d = '0;
          iter_d    = CNT_W'(WIDTH);
          busy_d    = 1'b1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_d = {adj[BCD_W-2:0], shreg_q[WIDTH-1]};
        shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
        iter_d    = iter_q - CNT_W'(1);
        if (iter_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        disp_d  = scratch_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      scratch_q <= '0;
      disp_q    <= '0;
      iter_q    <= '0;
      busy      <= 1'b0;
      conv_done <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      scratch_q <= scratch_d;
      disp_q    <= disp_d;
      iter_q    <= iter_d;
      busy      <= busy_d;
      conv_done <= done_d;
    end
  end

  // Free-running refresh counter; digit index advances on each wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_q <= '0;
      idx_q <= 2'd0;
    end else if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_q <= '0;
      idx_q <= (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
    end else begin
      ref_q <= ref_q + REF_W'(1);
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    digit_bcd = disp_q[3:0];
      2'd1:    digit_bcd = disp_q[7:4];
      default: digit_bcd = disp_q[11:8];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  always_comb begin
    blank = (ref_q < REF_W'(BLANK_CYCLES))
         || ((idx_q == 2'd2) && (disp_q[11:8] == 4'd0))
         || ((idx_q == 2'd1) && (disp_q[11:4] == 8'd0));
  end
`else
  always_comb begin
    blank = (ref_q < REF_W'(BLANK_CYCLES));
  end
`endif

  // Anode/cathode drive; the blanking window at slot start suppresses ghosting.
  always_comb begin
    an_n  = 4'b1111;
    seg_n = 7'h7F;
    if (!blank) begin
      an_n[idx_q] = 1'b0;
      seg_n       = ~seg_in;
    end
  end

endmodule
